// File: rtl/tog_event_decoder.sv
// tog_event_decoder: turns a toggle-encoded level into event pulses, queued in a saturating counter drained by valid/ack.
module tog_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             en,
    input  logic             evt_ack,
    input  logic             ovf_clr,
    output logic             q_sync,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_pending,
    output logic             ovf
);
    typedef enum logic [1:0] {ARM, LOAD, RUN} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic [1:0] arm_cnt;
    logic prev, inc, dec, full;
    assign q_sync    = sync[SYNC_STAGES-1];
    assign evt_valid = |evt_pending;
    assign full      = &evt_pending;
    assign inc       = (state == RUN) && (q_sync ^ prev) && en;
    assign dec       = evt_ack && evt_valid;
    // prev tracks q_sync in every state, so LOAD absorbs the level present at arming
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARM;
            arm_cnt     <= '0;
            sync        <= '0;
            prev        <= 1'b0;
            evt_pulse   <= 1'b0;
            evt_pending <= '0;
            ovf         <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], tog_in};
            prev        <= q_sync;
            evt_pulse   <= inc;
            arm_cnt     <= (state == ARM) ? arm_cnt + 2'd1 : arm_cnt;
            state       <= (state == ARM) ? ((arm_cnt == 2'(SYNC_STAGES-1)) ? LOAD : ARM) : RUN;
            evt_pending <= (inc && !dec && !full) ? evt_pending + 1'b1 :
                           (dec && !inc)          ? evt_pending - 1'b1 : evt_pending;
            ovf         <= (inc && !dec && full) || (ovf && !ovf_clr);
        end
    end
endmodule

// File: tb/tb_tog_event_decoder.sv
// tb_tog_event_decoder: directed checks of sync latency, saturation, ack, enable and async reset.
module tb_tog_event_decoder;
    logic clk = 1'b0;
    logic rst, tog_in, en, evt_ack, ovf_clr;
    logic q_sync, evt_pulse, evt_valid, ovf;
    logic [3:0] evt_pending;
    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p0;

    tog_event_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .tog_in(tog_in), .en(en), .evt_ack(evt_ack),
        .ovf_clr(ovf_clr), .q_sync(q_sync), .evt_pulse(evt_pulse),
        .evt_valid(evt_valid), .evt_pending(evt_pending), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (evt_pulse === 1'b1) pulses++;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; tog_in = 1'b1; en = 1'b1; evt_ack = 1'b0; ovf_clr = 1'b0;
        step(3);
        chk("rst_pending", 32'(evt_pending), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_qsync", 32'(q_sync), 0);
        chk("rst_ovf", 32'(ovf), 0);
        // release with tog_in already high: must not count
        rst = 1'b1;
        p0 = pulses;
        step(10);
        chk("arm_no_pulse", 32'(pulses - p0), 0);
        chk("arm_pending", 32'(evt_pending), 0);
        chk("arm_qsync", 32'(q_sync), 1);

        // single toggle: pulse exactly after 3rd edge
        tog_in = 1'b0;
        step(2);
        chk("lat_no_pulse_yet", 32'(evt_pulse), 0);
        chk("lat_pending_yet", 32'(evt_pending), 0);
        step();
        chk("lat_pulse", 32'(evt_pulse), 1);
        chk("lat_pending", 32'(evt_pending), 1);
        chk("lat_valid", 32'(evt_valid), 1);
        step();
        chk("lat_pulse_one_cycle", 32'(evt_pulse), 0);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk("ack_pending", 32'(evt_pending), 0);
        chk("ack_valid", 32'(evt_valid), 0);

        // 20 toggles without ack saturate at 15
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            tog_in = ~tog_in;
            step(4);
        end
        chk("sat_pulses", 32'(pulses - p0), 20);
        chk("sat_pending", 32'(evt_pending), 15);
        chk("sat_ovf", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_pending", 32'(evt_pending), 15);
        // saturating set and clear on the same edge: set wins
        tog_in = ~tog_in;
        step(2);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("set_wins_pulse", 32'(evt_pulse), 1);
        chk("set_wins_ovf", 32'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr2_ovf", 32'(ovf), 0);

        // drain to 5, then inc and dec on the same edge
        evt_ack = 1'b1;
        step(10);
        evt_ack = 1'b0;
        chk("drain_to5", 32'(evt_pending), 5);
        tog_in = ~tog_in;
        step(2);
        evt_ack = 1'b1;
        step();
        chk("incdec_pulse", 32'(evt_pulse), 1);
        chk("incdec_pending", 32'(evt_pending), 5);
        step(5);
        chk("drain_zero", 32'(evt_pending), 0);
        step(3);
        chk("no_underflow", 32'(evt_pending), 0);
        chk("no_underflow_valid", 32'(evt_valid), 0);
        evt_ack = 1'b0;

        // disabled toggles are discarded and never replayed
        en = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            tog_in = ~tog_in;
            step(4);
        end
        en = 1'b1;
        step(6);
        chk("en0_pulses", 32'(pulses - p0), 0);
        chk("en0_pending", 32'(evt_pending), 0);
        tog_in = ~tog_in;
        step(4);
        chk("reen_pulses", 32'(pulses - p0), 1);
        chk("reen_pending", 32'(evt_pending), 1);

        // build pending=7 with ovf, then async reset
        for (int i = 0; i < 16; i++) begin
            tog_in = ~tog_in;
            step(4);
        end
        evt_ack = 1'b1;
        step(8);
        evt_ack = 1'b0;
        chk("pre_rst_pending", 32'(evt_pending), 7);
        chk("pre_rst_ovf", 32'(ovf), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_pending", 32'(evt_pending), 0);
        chk("async_valid", 32'(evt_valid), 0);
        chk("async_ovf", 32'(ovf), 0);
        chk("async_qsync", 32'(q_sync), 0);
        step(2);
        rst = 1'b1;
        p0 = pulses;
        step(6);
        chk("rearm_no_pulse", 32'(pulses - p0), 0);
        chk("rearm_pending", 32'(evt_pending), 0);
        tog_in = ~tog_in;
        step(4);
        chk("rearm_first_evt", 32'(evt_pending), 1);
        chk("rearm_pulses", 32'(pulses - p0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
